// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch definitions: primary opcodes, REGIMM sub-ops and the link register index.
package branch_resolve_unit_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // *AL forms always write this register with the link address.
  localparam logic [4:0] LINK_REG  = 5'd31;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch µop request / resolved result bus, plus flush and perf counter taps.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_op;
  logic [4:0]      in_rt;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [XLEN-1:0] in_pc;
  logic [15:0]     in_imm;
  logic            in_pred_taken;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_link_we;
  logic [XLEN-1:0] out_link_pc;
  logic            out_illegal;
  logic [CNT_W-1:0] cnt_branches;
  logic [CNT_W-1:0] cnt_mispredicts;

  // Decode / pipeline-control side.
  modport master (
    output in_valid, in_op, in_rt, in_a, in_b, in_pc, in_imm, in_pred_taken,
    output flush, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc,
    input  out_link_we, out_link_pc, out_illegal, cnt_branches, cnt_mispredicts
  );

  // Branch resolution unit side.
  modport slave (
    input  in_valid, in_op, in_rt, in_a, in_b, in_pc, in_imm, in_pred_taken,
    input  flush, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc,
    output out_link_we, out_link_pc, out_illegal, cnt_branches, cnt_mispredicts
  );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition decode: direction, link-write and illegal flags.
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [4:0]      rt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken,
  output logic            is_link,
  output logic            illegal
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[XLEN-1];
  assign a_zero = (a == '0);

  // Decode opcode / REGIMM sub-op into the resolved direction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    taken   = 1'b0;
    is_link = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BLEZ: taken = a_neg | a_zero;
      OP_BGTZ: taken = ~a_neg & ~a_zero;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   taken = a_neg;
          RT_BGEZ:   taken = ~a_neg;
          RT_BLTZAL: begin taken = a_neg;  is_link = 1'b1; end
          RT_BGEZAL: begin taken = ~a_neg; is_link = 1'b1; end
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined branch resolution with valid/ready flow control and
// saturating perf counters. Integration note: in_ready is a combinational
// function of out_ready (no skid buffer), so the producer must not make
// in_valid depend on in_ready combinationally through out_ready.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 32,
  parameter int LINK_OFS = 8
) (
  input logic           clk,
  input logic           rst,
  branch_resolve_unit_if.slave bus
);

  logic            c_taken, c_link, c_illegal;
  logic [XLEN-1:0] c_target, c_link_pc;

  logic            s1_valid, s1_taken, s1_link, s1_illegal, s1_pred;
  logic [XLEN-1:0] s1_target, s1_link_pc;

  logic            s2_valid, s2_taken, s2_mispredict, s2_link_we, s2_illegal;
  logic [XLEN-1:0] s2_redirect_pc, s2_link_pc;

  logic [CNT_W-1:0] cnt_br, cnt_mp;

  logic s1_adv, s2_adv, accept, xfer;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .op      (bus.in_op),
    .rt      (bus.in_rt),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .taken   (c_taken),
    .is_link (c_link),
    .illegal (c_illegal)
  );

  // Target wraps modulo 2^XLEN; link/fall-through skips the delay slot.
  assign c_target  = bus.in_pc + XLEN'(4) + ({{(XLEN-16){bus.in_imm[15]}}, bus.in_imm} << 2);
  assign c_link_pc = bus.in_pc + XLEN'(LINK_OFS);

  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;
  assign accept       = bus.in_valid & s1_adv;
  assign xfer         = s2_valid & bus.out_ready;

  // Stage 1: capture the µop's compare result and target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid   <= 1'b0;
      s1_taken   <= 1'b0;
      s1_link    <= 1'b0;
      s1_illegal <= 1'b0;
      s1_pred    <= 1'b0;
      s1_target  <= '0;
      s1_link_pc <= '0;
    end else begin
      if (bus.flush)   s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_taken   <= c_taken;
        s1_link    <= c_link;
        s1_illegal <= c_illegal;
        s1_pred    <= bus.in_pred_taken;
        s1_target  <= c_target;
        s1_link_pc <= c_link_pc;
      end
    end
  end

  // Stage 2: register the resolved result; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid       <= 1'b0;
      s2_taken       <= 1'b0;
      s2_mispredict  <= 1'b0;
      s2_link_we     <= 1'b0;
      s2_illegal     <= 1'b0;
      s2_redirect_pc <= '0;
      s2_link_pc     <= '0;
    end else begin
      if (bus.flush)   s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_taken       <= s1_taken;
        s2_mispredict  <= s1_taken ^ s1_pred;
        s2_link_we     <= s1_link;
        s2_illegal     <= s1_illegal;
        s2_redirect_pc <= s1_taken ? s1_target : s1_link_pc;
        s2_link_pc     <= s1_link_pc;
      end
    end
  end

  // Saturating perf counters; an output transfer counts even when flush coincides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_br <= '0;
      cnt_mp <= '0;
    end else if (xfer && !s2_illegal) begin
      if (cnt_br != '1)                   cnt_br <= cnt_br + CNT_W'(1);
      if (s2_mispredict && cnt_mp != '1)  cnt_mp <= cnt_mp + CNT_W'(1);
    end
  end

  assign bus.out_valid       = s2_valid;
  assign bus.out_taken       = s2_taken;
  assign bus.out_mispredict  = s2_mispredict;
  assign bus.out_redirect_pc = s2_redirect_pc;
  assign bus.out_link_we     = s2_link_we;
  assign bus.out_link_pc     = s2_link_pc;
  assign bus.out_illegal     = s2_illegal;
  assign bus.cnt_branches    = cnt_br;
  assign bus.cnt_mispredicts = cnt_mp;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined branch-resolution unit for the MIPS core; replaces the single-cycle combinational branch comparator in decode.
- Accepts a branch µop (op, rt, operands, PC, imm, predicted direction), resolves direction/target over two registered stages with valid/ready handshake, flags mispredicts with redirect PC, link value for *AL forms.
- Keeps saturating branch/mispredict counters for perf CP0 reads.

Parameters:
- XLEN, 32, operand/PC width (32 or 64)
- CNT_W, 32, width of each performance counter
- LINK_OFS, 8, byte offset of link/fall-through address from branch PC (delay slot)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  µop present
- in_ready  out  1  unit can accept µop this cycle
- in_op  in  6  primary opcode
- in_rt  in  5  rt field (REGIMM sub-op)
- in_a  in  XLEN  rs value
- in_b  in  XLEN  rt value
- in_pc  in  XLEN  branch PC
- in_imm  in  16  offset field
- in_pred_taken  in  1  front-end prediction
- flush  in  1  kill all in-flight entries
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken  out  1  resolved direction
- out_mispredict  out  1  out_taken != predicted
- out_redirect_pc  out  XLEN  taken ? target : pc+LINK_OFS
- out_link_we  out  1  BLTZAL/BGEZAL (writes $31 regardless of direction)
- out_link_pc  out  XLEN  pc+LINK_OFS
- out_illegal  out  1  opcode not a branch (taken=0, mispredict=in_pred_taken)
- cnt_branches  out  CNT_W  resolved legal branches
- cnt_mispredicts  out  CNT_W  resolved mispredicts

Behaviour:
- Reset (async, rst=1): both stage valids 0, out_valid 0, all data outputs 0, counters 0; in_ready 1 after release.
- Decoded branches (shared constants): BEQ 000100 a==b; BNE 000101 a!=b; BLEZ 000110 a<=0 signed; BGTZ 000111 a>0 signed; REGIMM 000001 with rt BLTZ 00000 a<0, BGEZ 00001 a>=0, BLTZAL 10000 a<0, BGEZAL 10001 a>=0. Other REGIMM rt or other op -> illegal.
- BLEZ strictly signed (a[XLEN-1] | a==0), no precedence leakage into other opcodes.
- Target = pc + 4 + (sign-extended imm << 2), computed mod 2^XLEN (wraps silently).
- Stage 1 (S1): registers µop, computes compare result and target. Stage 2 (S2): registers taken/mispredict/redirect/link, drives out_*.
- Latency: 2 cycles in_valid&in_ready -> out_valid with no backpressure. Throughput 1/cycle.
- Handshake: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv. Outputs stable while out_valid & ~out_ready.
- in_ready combinational from out_ready (no skid); document this for integration.
- Counters increment on out_valid & out_ready transfer only: cnt_branches if ~out_illegal, cnt_mispredicts if mispredict & ~out_illegal. Saturate at all-ones, no wrap.
- flush: clears s1_valid, s2_valid next edge; µop presented with in_valid same cycle is dropped; no counter update for a transfer coinciding with flush... except the transfer at out with out_valid&out_ready same cycle as flush counts (already consumed).
- Reset mid-operation: all in-flight entries lost immediately, counters cleared.

Decomposition:
- Shared package/header branch_defs: opcode constants (BEQ, BNE, BLEZ, BGTZ, REGIMM), REGIMM rt codes, LINK register index 31.
- One sub-module: branch_cond (combinational, XLEN-parametrised): op, rt, a, b -> taken, is_link, illegal. Remaining logic (pipeline, handshake, counters) in top.

Test Plan:
- BEQ a=5,b=5, pc=0x1000, imm=0x0004, pred=0 -> after 2 cycles out_taken=1, mispredict=1, redirect=0x1014, cnt_mispredicts=1.
- BLEZ a=0x00000001 -> taken=0; a=0 -> taken=1; a=0x80000000 -> taken=1; BGTZ a=0x80000000 -> taken=0.
- BGEZAL a=0xFFFFFFFF, pc=0x2000, pred=0 -> taken=0, link_we=1, link_pc=0x2008, mispredict=0.
- Backpressure: 3 back-to-back µops, out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, first result held stable, all 3 delivered in order after release.
- flush with both stages full -> out_valid=0 next cycle, counters unchanged; REGIMM rt=00010 -> out_illegal=1, cnt_branches unchanged.
- Counter saturation with CNT_W=4: 20 branches -> cnt_branches=15; async rst mid-stream -> outputs 0 before next clk edge.
